spi_master_ctrl: RTL and testbench

// - SPI master driving the SPI slave + single-port RAM subsystem from a parallel command interface.
// - Takes a 10-bit command word {cmd[1:0], payload[7:0]} and frames it on SS_n/MOSI, MSB first.
// - For read-data commands, it captures the 8-bit MISO reply and returns it in parallel.
// - Serves as the bench-side initiator and as the on-chip host for the slave.

---
 rtl/spi_pkg.sv | 20 ++
 rtl/spi_master_ctrl_if.sv | 31 +++
 rtl/spi_master_ctrl.sv | 106 ++++++++++
 tb/tb_spi_master_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types for the SPI master: command encoding and controller states.
package spi_pkg;

  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    SHIFT,
    WAIT_RD,
    CAPTURE,
    GAP
  } state_e;

endpackage

// File: rtl/spi_master_ctrl_if.sv
// Parallel command/response bundle between a host and the SPI master.
interface spi_master_ctrl_if #(
  parameter int ADDR_SIZE = 8
) ();

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [ADDR_SIZE+1:0] cmd_din;
  logic [ADDR_SIZE-1:0] rd_data;
  logic                 rd_valid;
  logic                 busy;

  modport master (
    output cmd_valid,
    output cmd_din,
    input  cmd_ready,
    input  rd_data,
    input  rd_valid,
    input  busy
  );

  modport slave (
    input  cmd_valid,
    input  cmd_din,
    output cmd_ready,
    output rd_data,
    output rd_valid,
    output busy
  );

endinterface

// File: rtl/spi_master_ctrl.sv
// SPI master: frames {cmd,payload} on SS_n/MOSI MSB first; rd_data commands capture a MISO byte.
// One command per frame; cmd_ready only in IDLE, requests seen while busy are dropped.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int ADDR_SIZE  = 8,
  parameter int RD_LATENCY = 2,
  parameter int IDLE_GAP   = 1
) (
  input  logic               clk,
  input  logic               rst,
  spi_master_ctrl_if.slave   cmd_if,
  output logic               SS_n,
  output logic               MOSI,
  input  logic               MISO
);

  localparam int FRAME_BITS = ADDR_SIZE + 2;
  localparam int CNT_W      = $clog2(FRAME_BITS);
  localparam int WAIT_W     = $clog2(RD_LATENCY + 1);
  localparam int GAP_W      = $clog2(IDLE_GAP + 1);

  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0]  LAST_RX   = CNT_W'(ADDR_SIZE - 1);
  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(RD_LATENCY - 1);
  localparam logic [GAP_W-1:0]  LAST_GAP  = GAP_W'(IDLE_GAP - 1);

  state_e                state_q;
  state_e                state_d;
  cmd_e                  cmd_q;
  logic [FRAME_BITS-1:0] sr;
  logic [ADDR_SIZE-2:0]  rx_sr;
  logic [CNT_W-1:0]      bit_cnt;
  logic [WAIT_W-1:0]     wait_cnt;
  logic [GAP_W-1:0]      gap_cnt;
  logic                  accept;

  assign accept = cmd_if.cmd_valid && cmd_if.cmd_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = START;
      START:   state_d = SHIFT;
      SHIFT:   if (bit_cnt == LAST_BIT) state_d = (cmd_q == RD_DATA) ? WAIT_RD : GAP;
      WAIT_RD: if (wait_cnt == LAST_WAIT) state_d = CAPTURE;
      CAPTURE: if (bit_cnt == LAST_RX) state_d = GAP;
      GAP:     if (gap_cnt == LAST_GAP) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      cmd_q            <= WR_ADDR;
      sr               <= '0;
      rx_sr            <= '0;
      bit_cnt          <= '0;
      wait_cnt         <= '0;
      gap_cnt          <= '0;
      SS_n             <= 1'b1;
      MOSI             <= 1'b0;
      cmd_if.cmd_ready <= 1'b1;
      cmd_if.busy      <= 1'b0;
      cmd_if.rd_valid  <= 1'b0;
      cmd_if.rd_data   <= '0;
    end else begin
      state_q <= state_d;

      // every state starts its own count from zero
      if (state_d != state_q) begin
        bit_cnt  <= '0;
        wait_cnt <= '0;
        gap_cnt  <= '0;
      end else begin
        if (state_q == SHIFT || state_q == CAPTURE) bit_cnt <= bit_cnt + 1'b1;
        if (state_q == WAIT_RD) wait_cnt <= wait_cnt + 1'b1;
        if (state_q == GAP)     gap_cnt  <= gap_cnt + 1'b1;
      end

      if (state_q == IDLE && accept) begin
        sr    <= cmd_if.cmd_din;
        cmd_q <= cmd_e'(cmd_if.cmd_din[FRAME_BITS-1 -: 2]);
      end else if (state_d == SHIFT) begin
        sr <= {sr[FRAME_BITS-2:0], 1'b0};
      end

      cmd_if.rd_valid <= 1'b0;
      if (state_q == CAPTURE) begin
        rx_sr <= {rx_sr[ADDR_SIZE-3:0], MISO};
        if (state_d == GAP) begin
          cmd_if.rd_data  <= {rx_sr, MISO};
          cmd_if.rd_valid <= 1'b1;
        end
      end

      // pins follow the state being entered so they are registered and glitch-free
      SS_n             <= !(state_d inside {START, SHIFT, WAIT_RD, CAPTURE});
      MOSI             <= (state_d == SHIFT) ? sr[FRAME_BITS-1] : 1'b0;
      cmd_if.cmd_ready <= (state_d == IDLE);
      cmd_if.busy      <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl: table-driven frames, scoreboard of expected frames,
// and hand-written sequences for busy drop, back-to-back and mid-frame reset.
module tb_spi_master_ctrl;

  localparam int AS   = 8;
  localparam int RL   = 2;
  localparam int IG   = 1;
  localparam int FB   = AS + 2;
  localparam int CAP0 = 1 + FB + RL;

  typedef struct {
    logic [FB-1:0] word;
    int            len;
    int            rv;
    logic [AS-1:0] rd;
    bit            abort;
  } exp_t;

  typedef struct {
    logic [FB-1:0] din;
    logic [AS-1:0] miso;
    int            len;
    int            rv;
    logic [AS-1:0] rd_after;
  } vec_t;

  logic clk;
  logic rst;
  logic SS_n;
  logic MOSI;
  logic MISO;

  spi_master_ctrl_if #(.ADDR_SIZE(AS)) cif ();

  spi_master_ctrl #(
    .ADDR_SIZE (AS),
    .RD_LATENCY(RL),
    .IDLE_GAP  (IG)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .cmd_if(cif.slave),
    .SS_n  (SS_n),
    .MOSI  (MOSI),
    .MISO  (MISO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  exp_t          exp_q[$];
  vec_t          vecs[8];
  logic [AS-1:0] miso_byte = '0;

  bit            in_frame = 0;
  int            low_cnt = 0;
  logic [FB-1:0] word = '0;
  logic          start_mosi = 1'b0;
  int            rv_cnt = 0;
  int            hi_run = 0;
  int            hi_busy = 0;
  int            last_hi_run = 0;
  int            last_hi_busy = 0;
  int            frame_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fail(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    errors++;
    $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
  endtask

  task automatic frame_done();
    exp_t e;
    frame_cnt++;
    if (exp_q.size() == 0) begin
      fail("unexpected_frame_len", low_cnt, 0);
      rv_cnt = 0;
      return;
    end
    e = exp_q.pop_front();
    chk("frame_len", low_cnt, e.len);
    chk("start_mosi", start_mosi, 1'b0);
    if (!e.abort) chk("mosi_word", word, e.word);
    chk("rd_valid_count", rv_cnt, e.rv);
    rv_cnt = 0;
  endtask

  // Slave model and frame monitor, both working mid-cycle.
  always @(negedge clk) begin
    if (cif.rd_valid === 1'b1) begin
      rv_cnt++;
      if (exp_q.size() > 0) chk("rd_data_on_valid", cif.rd_data, exp_q[0].rd);
      else fail("rd_valid_unexpected", cif.rd_data, 0);
    end
    if (SS_n === 1'b0) begin
      if (!in_frame) begin
        in_frame     = 1;
        low_cnt      = 0;
        word         = '0;
        last_hi_run  = hi_run;
        last_hi_busy = hi_busy;
      end
      if (low_cnt == 0) start_mosi = MOSI;
      else if (low_cnt <= FB) word = {word[FB-2:0], MOSI};
      if (low_cnt >= CAP0 && low_cnt < CAP0 + AS) MISO = miso_byte[AS-1-(low_cnt-CAP0)];
      else MISO = 1'b0;
      low_cnt++;
    end else begin
      if (in_frame) begin
        in_frame = 0;
        frame_done();
        hi_run  = 0;
        hi_busy = 0;
      end
      hi_run++;
      if (cif.busy === 1'b1) hi_busy++;
      MISO = 1'b0;
    end
  end

  task automatic send(input logic [FB-1:0] d, input exp_t e);
    int n = 0;
    @(negedge clk);
    while (cif.cmd_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (cif.cmd_ready !== 1'b1) begin
      fail("send_ready_timeout", cif.cmd_ready, 1);
      return;
    end
    exp_q.push_back(e);
    cif.cmd_valid = 1'b1;
    cif.cmd_din   = d;
    @(posedge clk);
    #1;
    cif.cmd_valid = 1'b0;
    chk("accept_ready_drop", cif.cmd_ready, 1'b0);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk);
    while (cif.busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (cif.busy !== 1'b0) fail(tag, cif.busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1);
  end

  initial begin
    int f0;
    int n;
    exp_t e;

    vecs[0] = '{din: 10'h0A5, miso: 8'h00, len: 11, rv: 0, rd_after: 8'h00};
    vecs[1] = '{din: 10'h300, miso: 8'h3C, len: 21, rv: 1, rd_after: 8'h3C};
    vecs[2] = '{din: 10'h155, miso: 8'hFF, len: 11, rv: 0, rd_after: 8'h3C};
    vecs[3] = '{din: 10'h2C3, miso: 8'hFF, len: 11, rv: 0, rd_after: 8'h3C};
    vecs[4] = '{din: 10'h3FF, miso: 8'h81, len: 21, rv: 1, rd_after: 8'h81};
    vecs[5] = '{din: 10'h000, miso: 8'h55, len: 11, rv: 0, rd_after: 8'h81};
    vecs[6] = '{din: 10'h3AA, miso: 8'h00, len: 21, rv: 1, rd_after: 8'h00};
    vecs[7] = '{din: 10'h3C0, miso: 8'hFF, len: 21, rv: 1, rd_after: 8'hFF};

    rst           = 1'b1;
    MISO          = 1'b0;
    cif.cmd_valid = 1'b0;
    cif.cmd_din   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ss_n", SS_n, 1'b1);
    chk("reset_mosi", MOSI, 1'b0);
    chk("reset_cmd_ready", cif.cmd_ready, 1'b1);
    chk("reset_busy", cif.busy, 1'b0);
    chk("reset_rd_valid", cif.rd_valid, 1'b0);
    chk("reset_rd_data", cif.rd_data, 8'h00);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      miso_byte = vecs[i].miso;
      e = '{word: vecs[i].din, len: vecs[i].len, rv: vecs[i].rv, rd: vecs[i].rd_after, abort: 0};
      send(vecs[i].din, e);
      wait_idle("vec_busy_timeout");
      chk("vec_rd_data_after", cif.rd_data, vecs[i].rd_after);
      chk("vec_cmd_ready_after", cif.cmd_ready, 1'b1);
      chk("vec_mosi_after", MOSI, 1'b0);
    end

    // A request during SHIFT must be dropped, not queued.
    f0 = frame_cnt;
    send(10'h0C3, '{word: 10'h0C3, len: 11, rv: 0, rd: 8'hFF, abort: 0});
    repeat (3) @(negedge clk);
    chk("busy_drop_ready_low", cif.cmd_ready, 1'b0);
    cif.cmd_valid = 1'b1;
    cif.cmd_din   = 10'h2FF;
    @(posedge clk);
    #1;
    cif.cmd_valid = 1'b0;
    wait_idle("busy_drop_timeout");
    repeat (4) @(negedge clk);
    chk("busy_drop_frames", frame_cnt - f0, 1);
    chk("busy_drop_stays_idle", cif.busy, 1'b0);

    // Back-to-back: cmd_valid held across two frames.
    @(negedge clk);
    exp_q.push_back('{word: 10'h0FF, len: 11, rv: 0, rd: 8'hFF, abort: 0});
    cif.cmd_valid = 1'b1;
    cif.cmd_din   = 10'h0FF;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (cif.cmd_ready !== 1'b0 && n < 50);
    exp_q.push_back('{word: 10'h1AA, len: 11, rv: 0, rd: 8'hFF, abort: 0});
    cif.cmd_din = 10'h1AA;
    n = 0;
    while (cif.cmd_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (cif.cmd_ready !== 1'b1) fail("b2b_ready_timeout", cif.cmd_ready, 1);
    @(posedge clk);
    #1;
    cif.cmd_valid = 1'b0;
    wait_idle("b2b_busy_timeout");
    chk("b2b_gap_state_cycles", last_hi_busy, IG);
    chk("b2b_ss_high_cycles", last_hi_run, IG + 1);

    // Mid-frame reset at SHIFT bit 4 of an rd_data frame.
    miso_byte = 8'hC3;
    send(10'h3A5, '{word: 10'h3A5, len: 6, rv: 0, rd: 8'h00, abort: 1});
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset_ss_n", SS_n, 1'b1);
    chk("midreset_rd_valid", cif.rd_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("midreset_ready", cif.cmd_ready, 1'b1);

    miso_byte = 8'h5A;
    send(10'h3E1, '{word: 10'h3E1, len: 21, rv: 1, rd: 8'h5A, abort: 0});
    wait_idle("post_reset_timeout");
    chk("post_reset_rd_data", cif.rd_data, 8'h5A);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
